// File: rtl/pwm_capture_if.sv
// Result/handshake bundle for pwm_capture.
// The measuring block drives the result side (master); the consumer drives ack_i (slave).
interface pwm_capture_if;
    logic        ack_i;
    logic        valid_o;
    logic [11:0] high_o;
    logic [11:0] low_o;
    logic        on_o;
    logic        off_o;
    logic        err_o;
    logic        overrun_o;

    modport master (
        input  ack_i,
        output valid_o, high_o, low_o, on_o, off_o, err_o, overrun_o
    );

    modport slave (
        output ack_i,
        input  valid_o, high_o, low_o, on_o, off_o, err_o, overrun_o
    );
endinterface

// File: rtl/pwm_capture.sv
// Single-channel PWM capture.
// Samples pwm_i against the shared 12-bit period counter and, once per
// period, reports the rise/fall counter positions or a full-on/full-off/
// malformed classification through a valid/ack handshake.
module pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] counter_i,
    input  logic        wrap_i,
    input  logic        pwm_i,
    input  logic        invert_i,
    pwm_capture_if.master res
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_wrap_dly;
    logic [11:0]            r_cnt_dly [SYNC_STAGES];

    logic                   w_s;
    logic                   w_wrap_d;
    logic [11:0]            w_cnt_d;

    logic [1:0]             r_rise_cnt;
    logic [1:0]             r_fall_cnt;
    logic [11:0]            r_rise_val;
    logic [11:0]            r_fall_val;
    logic                   r_last_s;

    logic                   w_rise;
    logic                   w_fall;

    logic                   w_on;
    logic                   w_off;
    logic                   w_err;
    logic [11:0]            w_high;
    logic [11:0]            w_low;

    state_t                 r_state;
    logic                   r_valid;
    logic [11:0]            r_high;
    logic [11:0]            r_low;
    logic                   r_on;
    logic                   r_off;
    logic                   r_err;
    logic                   r_overrun;
    logic                   w_close;

    // The counter and wrap pulse are delayed by the synchronizer depth so each
    // sample is paired with the counter value that produced it.
    assign w_s      = r_sync[SYNC_STAGES-1] ^ invert_i;
    assign w_wrap_d = r_wrap_dly[SYNC_STAGES-1];
    assign w_cnt_d  = r_cnt_dly[SYNC_STAGES-1];

    // Synchronize pwm_i and delay counter/wrap by the same number of stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync     <= '0;
            r_wrap_dly <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_cnt_dly[i] <= '0;
            end
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], pwm_i};
            r_wrap_dly   <= {r_wrap_dly[SYNC_STAGES-2:0], wrap_i};
            r_cnt_dly[0] <= counter_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_cnt_dly[i] <= r_cnt_dly[i-1];
            end
        end
    end

    assign w_rise = w_s & ~r_last_s;
    assign w_fall = ~w_s & r_last_s;

    // Per-period edge accumulators; restarted from the wrap-cycle sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rise_cnt <= '0;
            r_fall_cnt <= '0;
            r_rise_val <= '0;
            r_fall_val <= '0;
            r_last_s   <= 1'b0;
        end else if (w_wrap_d) begin
            r_rise_cnt <= w_s ? 2'd1 : 2'd0;
            r_fall_cnt <= '0;
            r_rise_val <= '0;
            r_fall_val <= '0;
            r_last_s   <= w_s;
        end else begin
            if (w_rise) begin
                if (r_rise_cnt == 2'd0) begin
                    r_rise_val <= w_cnt_d;
                end
                if (r_rise_cnt != 2'd2) begin
                    r_rise_cnt <= r_rise_cnt + 2'd1;
                end
            end
            if (w_fall) begin
                if (r_fall_cnt == 2'd0) begin
                    r_fall_val <= w_cnt_d;
                end
                if (r_fall_cnt != 2'd2) begin
                    r_fall_cnt <= r_fall_cnt + 2'd1;
                end
            end
            r_last_s <= w_s;
        end
    end

    // Classify the period that ends at this wrap from the pre-clear accumulators.
    always_comb begin
        w_on   = 1'b0;
        w_off  = 1'b0;
        w_err  = 1'b0;
        w_high = '0;
        w_low  = '0;
        if (r_rise_cnt == 2'd0 && !r_last_s) begin
            w_off = 1'b1;
        end else if (r_rise_cnt == 2'd1 && r_fall_cnt == 2'd0 &&
                     r_rise_val == 12'd0 && r_last_s) begin
            w_on = 1'b1;
        end else if (r_rise_cnt == 2'd1 && r_fall_cnt == 2'd1 &&
                     r_rise_val < r_fall_val && !r_last_s) begin
            w_high = r_rise_val;
            w_low  = r_fall_val;
        end else begin
            w_err = 1'b1;
        end
    end

    assign w_close = w_wrap_d && (r_state == ST_MEASURE);

    // Measurement FSM with registered result/handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_high    <= '0;
            r_low     <= '0;
            r_on      <= 1'b0;
            r_off     <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The period in progress at reset release is incomplete.
                    if (w_wrap_d) begin
                        r_state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_close) begin
                        r_high    <= w_high;
                        r_low     <= w_low;
                        r_on      <= w_on;
                        r_off     <= w_off;
                        r_err     <= w_err;
                        r_valid   <= 1'b1;
                        // A same-cycle ack consumes the old result, so no overrun.
                        r_overrun <= r_valid & ~res.ack_i;
                    end else if (res.ack_i && r_valid) begin
                        r_valid   <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign res.valid_o   = r_valid;
    assign res.high_o    = r_high;
    assign res.low_o     = r_low;
    assign res.on_o      = r_on;
    assign res.off_o     = r_off;
    assign res.err_o     = r_err;
    assign res.overrun_o = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives a 4096-count period counter and a
// waveform defined as up to two high intervals [a1,b1) and [a2,b2).
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [11:0] counter_i;
    logic        wrap_i;
    logic        pwm_i;
    logic        invert_i;

    pwm_capture_if u_if ();

    pwm_capture #(.SYNC_STAGES(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .counter_i (counter_i),
        .wrap_i    (wrap_i),
        .pwm_i     (pwm_i),
        .invert_i  (invert_i),
        .res       (u_if)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   pos   = 0;
    int   div   = 1;
    int   a1, b1, a2, b2;
    logic inv_wave = 1'b0;

    function automatic logic wave(input int c);
        return ((c >= a1) && (c < b1)) || ((c >= a2) && (c < b2));
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic v, input logic [11:0] h,
                             input logic [11:0] l, input logic on, input logic off,
                             input logic err, input logic ovr);
        chk({tag, ".valid"},   u_if.valid_o,   12'(v));
        chk({tag, ".high"},    u_if.high_o,    h);
        chk({tag, ".low"},     u_if.low_o,     l);
        chk({tag, ".on"},      u_if.on_o,      12'(on));
        chk({tag, ".off"},     u_if.off_o,     12'(off));
        chk({tag, ".err"},     u_if.err_o,     12'(err));
        chk({tag, ".overrun"}, u_if.overrun_o, 12'(ovr));
    endtask

    // One clock: drive counter/wrap/pwm for position pos, then sample #1 after the edge.
    task automatic step();
        int c;
        c         = pos / div;
        counter_i = 12'(c);
        wrap_i    = (pos == 0);
        pwm_i     = wave(c) ^ inv_wave;
        @(posedge clk);
        #1;
        pos = (pos + 1) % (4096 * div);
    endtask

    // Finish the current period, switch the waveform for the next one and run
    // two clocks past the wrap; the following step() is the close edge.
    // invert_i follows two clocks late so it lines up with the synchronized samples.
    task automatic next_period(input int nd, input logic ninv, input int na1, input int nb1,
                               input int na2, input int nb2);
        while (pos != 0) step();
        div      = nd;
        inv_wave = ninv;
        a1 = na1; b1 = nb1; a2 = na2; b2 = nb2;
        step();
        step();
        invert_i = inv_wave;
    endtask

    task automatic ack_step(input string tag);
        u_if.ack_i = 1'b1;
        step();
        u_if.ack_i = 1'b0;
        chk({tag, ".ack_valid"},   u_if.valid_o,   12'd0);
        chk({tag, ".ack_overrun"}, u_if.overrun_o, 12'd0);
    endtask

    initial begin
        rst_i      = 1'b1;
        u_if.ack_i = 1'b0;
        invert_i   = 1'b0;
        counter_i  = '0;
        wrap_i     = 1'b0;
        pwm_i      = 1'b0;
        a1 = 100; b1 = 2000; a2 = 0; b2 = 0;

        repeat (5) step();
        check_res("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;

        // First wrap after reset only arms the FSM.
        next_period(1, 0, 100, 2000, 0, 0);
        step();
        chk("first_wrap.valid", u_if.valid_o, 12'd0);

        // Second wrap: result exactly three clocks after wrap_i.
        next_period(1, 0, 0, 4096, 0, 0);
        chk("latency.pre", u_if.valid_o, 12'd0);
        step();
        check_res("pulse100_2000", 1, 100, 2000, 0, 0, 0, 0);
        ack_step("pulse100_2000");

        next_period(1, 0, 0, 0, 0, 0);
        step();
        check_res("const1", 1, 0, 0, 1, 0, 0, 0);
        ack_step("const1");

        next_period(1, 0, 0, 4095, 0, 0);
        step();
        check_res("const0", 1, 0, 0, 0, 1, 0, 0);
        ack_step("const0");

        next_period(1, 0, 10, 20, 30, 40);
        step();
        check_res("h0_l4095", 1, 0, 4095, 0, 0, 0, 0);
        ack_step("h0_l4095");

        next_period(1, 0, 4000, 4096, 0, 0);
        step();
        check_res("two_pulse", 1, 0, 0, 0, 0, 1, 0);
        ack_step("two_pulse");

        next_period(1, 0, 100, 2000, 0, 0);
        step();
        check_res("tail_high", 1, 0, 0, 0, 0, 1, 0);

        // Left unacknowledged: the next close overwrites and flags overrun.
        next_period(4, 1, 10, 20, 0, 0);
        step();
        check_res("overrun", 1, 100, 2000, 0, 0, 0, 1);
        ack_step("overrun");

        next_period(1, 0, 200, 3000, 0, 0);
        step();
        check_res("invert_div4", 1, 10, 20, 0, 0, 0, 0);

        // Ack in the close cycle: new result loads, no overrun.
        next_period(1, 0, 200, 3000, 0, 0);
        u_if.ack_i = 1'b1;
        step();
        u_if.ack_i = 1'b0;
        check_res("ack_at_close", 1, 200, 3000, 0, 0, 0, 0);

        // Reset pulse mid-period at counter 1000.
        while (pos != 1000) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_res("mid_reset", 0, 0, 0, 0, 0, 0, 0);

        next_period(1, 0, 200, 3000, 0, 0);
        step();
        chk("post_reset_wrap1.valid", u_if.valid_o, 12'd0);

        next_period(1, 0, 200, 3000, 0, 0);
        step();
        check_res("post_reset_wrap2", 1, 200, 3000, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
